regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V core, successor to the single-write/dual-read register file. It provides a configurable number of read ports, two prioritised write ports (e.g. ALU and load writeback), a per-register pending-write scoreboard for issue hazard checks, and a hardware zero-sweep state machine that initialises or clears the array. It sits between the decode/issue stage (reads, allocation) and the writeback stages (writes).

---
 rtl/regfile_mp.sv | 158 +++++++++++++++
 tb/tb_regfile_mp.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with two prioritised write
// ports, a per-register pending-write scoreboard and a hardware zero-sweep
// that initialises or clears the array.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports and to hide pending bits that a same-cycle write is about
// to clear. When it is undefined, reads come from the array only.
//
// Handshake: there is no valid/ready pairing here. rdy is a global enable:
// when it is low nothing (array, pending bits, FSM, sweep counter) changes.
// A write or alloc is accepted on a posedge where rdy=1 and busy=0.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clr_req,
    output logic                busy,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      pend,
    output logic                dbg_state,
    output logic [AW-1:0]       dbg_cnt
);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   mem [1:NREG-1];
    logic [NREG-1:0]   pend_q, pend_d;
    logic              ok0, ok1, oka;

    // Address 0 is hardwired zero; addresses past the array are ignored.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    assign ok0 = we0 && addr_ok(waddr0);
    assign ok1 = we1 && addr_ok(waddr1);
    assign oka = alloc_en && addr_ok(alloc_addr);

    assign busy      = (state_q == SWEEP);
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

    // FSM state and sweep counter; reset restarts the sweep from x1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SWEEP;
            cnt_q   <= AW'(1);
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep walks x1..x(NREG-1), clr_req from IDLE restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                if (int'(cnt_q) == NREG - 1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    cnt_d   = AW'(1);
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = AW'(1);
            end
        endcase
    end

    // Array storage: sweep zeroes one register per cycle, otherwise port 1
    // is written after port 0 so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (rdy && !rst) begin
            if (state_q == SWEEP) begin
                mem[cnt_q] <= '0;
            end else begin
                if (ok0) mem[waddr0] <= wdata0;
                if (ok1) mem[waddr1] <= wdata1;
            end
        end
    end

    // Next pending bits: writes clear, alloc sets last so it wins a tie.
    always_comb begin
        pend_d = pend_q;
        if (state_q == SWEEP || clr_req) begin
            pend_d = '0;
        end else begin
            if (ok0) pend_d[waddr0] = 1'b0;
            if (ok1) pend_d[waddr1] = 1'b0;
            if (oka) pend_d[alloc_addr] = 1'b1;
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else if (rdy) begin
            pend_q <= pend_d;
        end
    end

    // Combinational read ports; zero during reset, sweep, or for x0/invalid.
    always_comb begin
        logic [AW-1:0] a;
        rdata = '0;
        pend  = '0;
        for (int k = 0; k < NRD; k++) begin
            a = raddr[k*AW +: AW];
            if (!rst && state_q == IDLE && re[k] && addr_ok(a)) begin
                rdata[k*XLEN +: XLEN] = mem[a];
                pend[k]               = pend_q[a];
`ifdef REGFILE_BYPASS_EN
                if (ok1 && waddr1 == a) begin
                    rdata[k*XLEN +: XLEN] = wdata1;
                end else if (ok0 && waddr0 == a) begin
                    rdata[k*XLEN +: XLEN] = wdata0;
                end
                if (((ok0 && waddr0 == a) || (ok1 && waddr1 == a)) &&
                    !(oka && alloc_addr == a)) begin
                    pend[k] = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomised checks of regfile_mp against a
// behavioural register-file model (array of values, array of pending flags,
// a "busy / next register to clear" sweep tracker).
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                clk;
    logic                rst;
    logic                rdy;
    logic                clr_req;
    logic                busy;
    logic                we0, we1, alloc_en;
    logic [AW-1:0]       waddr0, waddr1, alloc_addr;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic [NRD-1:0]      re;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      pend;
    logic                dbg_state;
    logic [AW-1:0]       dbg_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    logic [XLEN-1:0] m_mem [NREG];
    bit              m_pend [NREG];
    bit              m_busy;
    int              m_next;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr_req(clr_req), .busy(busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .re(re), .raddr(raddr), .rdata(rdata), .pend(pend),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit ok(int a);
        return (a != 0) && (a < NREG);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(int k);
        int a;
        a = int'(raddr[k*AW +: AW]);
        if (rst || m_busy || !re[k] || !ok(a)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && int'(waddr1) == a) return wdata1;
        if (we0 && int'(waddr0) == a) return wdata0;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_pd(int k);
        int a;
        a = int'(raddr[k*AW +: AW]);
        if (rst || m_busy || !re[k] || !ok(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((we0 && int'(waddr0) == a) || (we1 && int'(waddr1) == a)) &&
            !(alloc_en && int'(alloc_addr) == a)) return 1'b0;
`endif
        return logic'(m_pend[a]);
    endfunction

    task automatic model_reset();
        m_busy = 1'b1;
        m_next = 1;
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    endtask

    // Apply the architectural effect of one clock edge to the model.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        if (m_busy) begin
            m_mem[m_next] = '0;
            m_next++;
            if (m_next == NREG) m_busy = 1'b0;
        end else begin
            if (we0 && ok(int'(waddr0))) m_mem[waddr0] = wdata0;
            if (we1 && ok(int'(waddr1))) m_mem[waddr1] = wdata1;
            if (clr_req) begin
                model_reset();
            end else begin
                if (we0 && ok(int'(waddr0))) m_pend[waddr0] = 1'b0;
                if (we1 && ok(int'(waddr1))) m_pend[waddr1] = 1'b0;
                if (alloc_en && ok(int'(alloc_addr))) m_pend[alloc_addr] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cmp(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    // Settle combinational outputs, then compare every output to the model.
    task automatic check(input string tag);
        #1;
        cmp({tag, ".busy"}, XLEN'(busy), XLEN'(m_busy));
        for (int k = 0; k < NRD; k++) begin
            cmp($sformatf("%s.rdata%0d", tag, k), rdata[k*XLEN +: XLEN], exp_rd(k));
            cmp($sformatf("%s.pend%0d", tag, k), XLEN'(pend[k]), XLEN'(exp_pd(k)));
        end
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; clr_req = 1'b0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        alloc_en = 1'b0; alloc_addr = '0;
        re = '0; raddr = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        re[k] = 1'b1;
        raddr[k*AW +: AW] = AW'(a);
    endtask

    // Run until busy drops (bounded) and return the number of edges taken.
    task automatic run_sweep(input string tag, input bit rdy_gap, output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            if (rdy_gap) begin
                rdy = !(cnt >= 5 && cnt < 8);
                we0 = 1'b1; waddr0 = AW'($urandom_range(1, NREG - 1));
                wdata0 = $urandom | 32'h1;
                alloc_en = 1'b1; alloc_addr = AW'($urandom_range(1, NREG - 1));
            end
            tick();
            cnt++;
            check(tag);
        end
        idle_inputs();
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < NREG; a++) begin
            re = '0;
            set_rd(0, a);
            set_rd(1, NREG - 1 - a);
            check(tag);
            tick();
        end
        re = '0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < NREG; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
        end
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        set_rd(0, 3);
        set_rd(1, 4);
        check("reset");
        tick();
        rst = 1'b0;
        check("post_reset");

        // Initial sweep: 31 cycles, then every register reads 0.
        run_sweep("sweep0", 1'b0, cnt);
        cmp("sweep0_len", XLEN'(cnt), XLEN'(31));
        read_all("zero0");

        // Simultaneous writes to x5: port 1 wins.
        we0 = 1'b1; waddr0 = 5; wdata0 = 32'h1234;
        we1 = 1'b1; waddr1 = 5; wdata1 = 32'hABCD;
        set_rd(0, 5);
        check("wcoll_same");
        tick();
        we0 = 1'b0; we1 = 1'b0;
        check("wcoll_next");
        cmp("wcoll_val", rdata[XLEN-1:0], 32'hABCD);

        // Alloc x7, write two cycles later, then alloc+write together.
        re = '0; set_rd(1, 7);
        alloc_en = 1'b1; alloc_addr = 7;
        tick();
        alloc_en = 1'b0;
        check("alloc_gap1");
        cmp("alloc_pend", XLEN'(pend[1]), XLEN'(1));
        tick();
        check("alloc_gap2");
        we0 = 1'b1; waddr0 = 7; wdata0 = 32'h55;
        check("alloc_wr_same");
        tick();
        we0 = 1'b0;
        check("alloc_after");
        cmp("alloc_clr", XLEN'(pend[1]), XLEN'(0));
        alloc_en = 1'b1; alloc_addr = 7;
        we1 = 1'b1; waddr1 = 7; wdata1 = 32'h66;
        tick();
        alloc_en = 1'b0; we1 = 1'b0;
        check("alloc_tie");
        cmp("alloc_tie_pend", XLEN'(pend[1]), XLEN'(1));

        // x0 writes dropped; disabled port reads 0.
        we0 = 1'b1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1'b1; waddr1 = 3; wdata1 = 32'h3333;
        alloc_en = 1'b1; alloc_addr = 0;
        tick();
        idle_inputs();
        set_rd(0, 0);
        raddr[AW +: AW] = 3;
        check("x0_re0");

        // Fill x1..x31 non-zero, then clear with a 3-cycle rdy gap.
        for (int a = 1; a < NREG; a++) begin
            we0 = 1'b1; waddr0 = AW'(a); wdata0 = $urandom | 32'h1;
            tick();
        end
        idle_inputs();
        set_rd(0, 9); set_rd(1, 31);
        check("filled");
        clr_req = 1'b1;
        alloc_en = 1'b1; alloc_addr = 9;
        tick();
        idle_inputs();
        check("clr_start");
        run_sweep("clr_sweep", 1'b1, cnt);
        cmp("clr_len", XLEN'(cnt), XLEN'(34));
        read_all("zero1");

        // Reset while idle with a pending bit set.
        alloc_en = 1'b1; alloc_addr = 9;
        tick();
        alloc_en = 1'b0;
        set_rd(0, 9);
        check("pend_pre_rst");
        #2;
        rst = 1'b1;
        model_reset();
        check("rst_idle");
        tick();
        rst = 1'b0;
        run_sweep("sweep_rst1", 1'b0, cnt);
        cmp("sweep_rst1_len", XLEN'(cnt), XLEN'(31));
        set_rd(0, 9);
        check("pend_post_rst");

        // Reset at sweep counter 10.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        cmp("cnt10", XLEN'(dbg_cnt), XLEN'(m_next));
        #2;
        rst = 1'b1;
        model_reset();
        set_rd(0, 5);
        check("rst_mid");
        tick();
        rst = 1'b0;
        run_sweep("sweep_rst2", 1'b0, cnt);
        cmp("sweep_rst2_len", XLEN'(cnt), XLEN'(31));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rdy        = ($urandom_range(0, 7) != 0);
            clr_req    = ($urandom_range(0, 63) == 0);
            we0        = $urandom_range(0, 1);
            waddr0     = AW'($urandom_range(0, NREG - 1));
            wdata0     = $urandom;
            we1        = $urandom_range(0, 1);
            waddr1     = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, NREG - 1));
            wdata1     = $urandom;
            alloc_en   = $urandom_range(0, 1);
            alloc_addr = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, NREG - 1));
            re         = NRD'($urandom_range(0, (1 << NRD) - 1));
            for (int k = 0; k < NRD; k++) begin
                raddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, NREG - 1));
            end
            check("rand");
            tick();
        end
        idle_inputs();
        check("rand_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
